// File: rtl/mcpu_avl_sram_model_pkg.sv
// Shared Avalon-MM definitions for the LTC-to-memory-controller port:
// bus widths, burst FSM state encodings and the stall LFSR step function.
package mcpu_avl_sram_model_pkg;

  localparam int AVL_DATA_W = 128;
  localparam int AVL_BE_W   = 16;
  localparam int AVL_SIZE_W = 5;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RD_WAIT  = 2'd1;
  localparam logic [1:0] ST_RD_BURST = 2'd2;
  localparam logic [1:0] ST_WR_BURST = 2'd3;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/mcpu_avl_stall_lfsr.sv
// 16-bit Galois LFSR used to generate pseudo-random wait-states.
module mcpu_avl_stall_lfsr
  import mcpu_avl_sram_model_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clkrst_core_clk,
  input  logic        clkrst_core_rst,
  input  logic        en,
  output logic [15:0] state
);

  // Advance the sequence whenever enabled; reset reloads the seed.
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      state <= SEED;
    end else if (en) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/mcpu_avl_sram_model.sv
// Avalon-MM burst slave backed by a 128-bit on-chip array. Gives the LTC
// port DRAM-like read latency, optional random wait-states and real data.
module mcpu_avl_sram_model
  import mcpu_avl_sram_model_pkg::*;
#(
  parameter int          ADDR_W     = 25,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          RD_LATENCY = 4,
  parameter int          STALL_EN   = 0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clkrst_core_clk,
  input  logic                  clkrst_core_rst,
  input  logic [ADDR_W-1:0]     ltc2mc_avl_addr_0,
  input  logic [AVL_BE_W-1:0]   ltc2mc_avl_be_0,
  input  logic                  ltc2mc_avl_burstbegin_0,
  input  logic                  ltc2mc_avl_read_req_0,
  input  logic                  ltc2mc_avl_write_req_0,
  input  logic [AVL_SIZE_W-1:0] ltc2mc_avl_size_0,
  input  logic [AVL_DATA_W-1:0] ltc2mc_avl_wdata_0,
  output logic                  ltc2mc_avl_ready_0,
  output logic [AVL_DATA_W-1:0] ltc2mc_avl_rdata_0,
  output logic                  ltc2mc_avl_rdata_valid_0,
  output logic                  avl_err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [AVL_DATA_W-1:0] mem [0:DEPTH-1];

  logic [1:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] base_q, base_d;
  logic [4:0]            len_q, len_d;
  logic [4:0]            beat_q, beat_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  rvalid_q;
  logic [AVL_DATA_W-1:0] rdata_q;
  logic                  err_q, err_d;

  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] addr_idx;
  logic [4:0]            size_len;
  logic [15:0]           lfsr_state;
  logic [15:0]           lfsr_next;
  logic                  stall_d;
  logic                  unused_addr_bits;

  assign addr_idx         = ltc2mc_avl_addr_0[DEPTH_LOG2-1:0];
  assign unused_addr_bits = ^ltc2mc_avl_addr_0[ADDR_W-1:DEPTH_LOG2];
  assign size_len         = (ltc2mc_avl_size_0 == '0) ? 5'd1 : ltc2mc_avl_size_0;

  mcpu_avl_stall_lfsr #(
    .SEED (LFSR_SEED)
  ) u_stall_lfsr (
    .clkrst_core_clk (clkrst_core_clk),
    .clkrst_core_rst (clkrst_core_rst),
    .en              (1'b1),
    .state           (lfsr_state)
  );

  // ready is registered, so the stall decision looks at the LFSR value of the
  // cycle in which ready will be visible.
  assign lfsr_next = lfsr_step(lfsr_state);
  assign stall_d   = (STALL_EN != 0) && (lfsr_next[1:0] == 2'b00);

  // Burst FSM: accepts, beat sequencing, array write strobes and error detection.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_idx  = base_q + DEPTH_LOG2'(beat_q);
    rd_idx  = base_q + DEPTH_LOG2'(beat_q);
    case (state_q)
      ST_IDLE: begin
        if (ready_q) begin
          if (ltc2mc_avl_write_req_0) begin
            // A concurrent read is dropped; a write without burstbegin is ignored.
            if (ltc2mc_avl_read_req_0 || !ltc2mc_avl_burstbegin_0) begin
              err_d = 1'b1;
            end
            if (ltc2mc_avl_burstbegin_0) begin
              wr_en  = 1'b1;
              wr_idx = addr_idx;
              base_d = addr_idx;
              len_d  = size_len;
              beat_d = 5'd1;
              if (size_len != 5'd1) begin
                state_d = ST_WR_BURST;
              end
            end
          end else if (ltc2mc_avl_read_req_0) begin
            base_d  = addr_idx;
            len_d   = size_len;
            beat_d  = 5'd0;
            cnt_d   = 4'(RD_LATENCY - 1);
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RD_BURST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RD_BURST: begin
        beat_d = beat_q + 5'd1;
        if (beat_q == len_q - 5'd1) begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_BURST: begin
        if (ltc2mc_avl_read_req_0 ||
            (ltc2mc_avl_write_req_0 && ltc2mc_avl_burstbegin_0)) begin
          err_d = 1'b1;
        end
        if (ltc2mc_avl_write_req_0 && ready_q) begin
          wr_en  = 1'b1;
          beat_d = beat_q + 5'd1;
          if (beat_q == len_q - 5'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // ready stays low for the cycle carrying the last read beat.
    ready_d = ((state_d == ST_IDLE) || (state_d == ST_WR_BURST)) &&
              (state_q != ST_RD_BURST) && !stall_d;
  end

  // Control and output registers.
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      rvalid_q <= (state_q == ST_RD_BURST);
      err_q    <= err_d;
      if (state_q == ST_RD_BURST) begin
        rdata_q <= mem[rd_idx];
      end
    end
  end

  // Burst bookkeeping; always loaded at accept so it needs no reset.
  always_ff @(posedge clkrst_core_clk) begin
    base_q <= base_d;
    len_q  <= len_d;
    beat_q <= beat_d;
    cnt_q  <= cnt_d;
  end

  // Array write port with per-byte enables.
  always_ff @(posedge clkrst_core_clk) begin
    if (wr_en) begin
      for (int i = 0; i < AVL_BE_W; i++) begin
        if (ltc2mc_avl_be_0[i]) begin
          mem[wr_idx][i*8 +: 8] <= ltc2mc_avl_wdata_0[i*8 +: 8];
        end
      end
    end
  end

  assign ltc2mc_avl_ready_0       = ready_q;
  assign ltc2mc_avl_rdata_0       = rdata_q;
  assign ltc2mc_avl_rdata_valid_0 = rvalid_q;
  assign avl_err                  = err_q;

endmodule
